// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_divider_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_M = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: compare the shifted partial remainder against
// the divisor and subtract when it fits.
module div_step #(
    parameter int M = 2
) (
    input  logic [M:0]   part_rem,
    input  logic [M-1:0] divisor,
    output logic [M-1:0] next_rem,
    output logic         q_bit
);

    logic [M:0] divisor_ext_s;

    assign divisor_ext_s = {1'b0, divisor};

    // The result always fits in M bits because it ends up below the divisor;
    // a zero divisor keeps the low bits, which is the intended wrap behaviour.
    always_comb begin
        next_rem = part_rem[M-1:0];
        q_bit    = 1'b0;
        if (part_rem >= divisor_ext_s) begin
            next_rem = part_rem[M-1:0] - divisor;
            q_bit    = 1'b1;
        end else begin
            next_rem = part_rem[M-1:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Define SEQ_DIVIDER_DBZ_EN to short-circuit division by zero with a flag.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_e         state_r;
    state_e         state_next_s;
    logic [CW-1:0]  cnt_r;
    logic [N-1:0]   quo_r;
    logic [M-1:0]   rem_r;
    logic [M-1:0]   dvsr_r;
    logic           busy_r;
    logic           done_r;
    logic           accept_s;
    logic           bypass_s;
    logic           last_step_s;
    logic [M:0]     shift_rem_s;
    logic [M-1:0]   step_rem_s;
    logic           step_q_s;

    // quo_r doubles as the dividend shifter: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    assign accept_s    = start && (state_r != RUN);
    assign last_step_s = (cnt_r == LAST_CNT);
    assign shift_rem_s = {rem_r, quo_r[N-1]};

    div_step #(.M(M)) u_step (
        .part_rem (shift_rem_s),
        .divisor  (dvsr_r),
        .next_rem (step_rem_s),
        .q_bit    (step_q_s)
    );

`ifdef SEQ_DIVIDER_DBZ_EN
    logic zero_div_s;
    logic dbz_r;

    assign zero_div_s = (divisor == {M{1'b0}});
    assign bypass_s   = accept_s && zero_div_s;

    // Flag follows the divisor of the most recently accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_r <= 1'b0;
        end else if (accept_s) begin
            dbz_r <= zero_div_s;
        end else begin
            dbz_r <= dbz_r;
        end
    end

    assign div_by_zero = dbz_r;
`else
    assign bypass_s    = 1'b0;
    assign div_by_zero = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    if (bypass_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_step_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand capture and one restoring step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            quo_r  <= {N{1'b0}};
            rem_r  <= {M{1'b0}};
            dvsr_r <= {M{1'b0}};
        end else if (accept_s) begin
            cnt_r  <= {CW{1'b0}};
            rem_r  <= {M{1'b0}};
            dvsr_r <= divisor;
            if (bypass_s) begin
                quo_r <= {N{1'b1}};
            end else begin
                quo_r <= dividend;
            end
        end else if (state_r == RUN) begin
            cnt_r <= cnt_r + CW'(1);
            quo_r <= {quo_r[N-2:0], step_q_s};
            rem_r <= step_rem_s;
        end else begin
            cnt_r  <= cnt_r;
            quo_r  <= quo_r;
            rem_r  <= rem_r;
            dvsr_r <= dvsr_r;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized
// operands against an arithmetic reference (honours SEQ_DIVIDER_DBZ_EN).
module tb_seq_divider;

    localparam int N = 4;
    localparam int M = 2;
    localparam int TMO = 4 * N + 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.N(N), .M(M)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; latency counts cycles from the
    // start edge to the cycle where done is seen (start->done = N+1).
    function automatic void ref_div(input int dd, input int ds, output int q, output int r,
                                    output int z, output int lat, output int bc);
        if (ds == 0) begin
            q = (1 << N) - 1;
`ifdef SEQ_DIVIDER_DBZ_EN
            r = 0; z = 1; lat = 1; bc = 0;
`else
            r = dd % (1 << M); z = 0; lat = N + 1; bc = N;
`endif
        end else begin
            q = dd / ds; r = dd % ds; z = 0; lat = N + 1; bc = N;
        end
    endfunction

    // Issue one start and wait (bounded) for done; lat = -1 on timeout.
    task automatic run_div(input logic [N-1:0] dd, input logic [M-1:0] ds,
                           output int q, output int r, output int z, output int lat, output int bc);
        @(negedge clk);
        dividend = dd; divisor = ds; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; bc = 0;
        for (int c = 0; c < TMO; c++) begin
            if (done) begin lat = c + 1; break; end
            bc += int'(busy);
            @(posedge clk); #1;
        end
        q = int'(quotient); r = int'(remainder); z = int'(div_by_zero);
    endtask

    task automatic test_reset();
        start = 1'b0; dividend = 4'd0; divisor = 2'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero}); end
        checks++; if (quotient !== 4'd0) begin errors++; $display("FAIL reset_quotient got %0d want 0", quotient); end
        checks++; if (remainder !== 2'd0) begin errors++; $display("FAIL reset_remainder got %0d want 0", remainder); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL idle_after_reset got %b want 00", {busy, done}); end
    endtask

    task automatic test_directed();
        int q, r, z, lat, bc;
        run_div(4'd13, 2'd3, q, r, z, lat, bc);
        checks++; if (lat !== N + 1) begin errors++; $display("FAIL d13_3_latency got %0d want %0d", lat, N + 1); end
        checks++; if (bc !== N) begin errors++; $display("FAIL d13_3_busy_cycles got %0d want %0d", bc, N); end
        checks++; if (q !== 4 || r !== 1) begin errors++; $display("FAIL d13_3_result got q=%0d r=%0d want q=4 r=1", q, r); end
        // Result must stay stable in IDLE with no further done pulse.
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (quotient !== 4'd4 || remainder !== 2'd1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL d13_3_hold got q=%0d r=%0d done=%b busy=%b want q=4 r=1 done=0 busy=0", quotient, remainder, done, busy);
        end
        run_div(4'd9, 2'd3, q, r, z, lat, bc);
        checks++; if (q !== 3 || r !== 0) begin errors++; $display("FAIL d9_3_result got q=%0d r=%0d want q=3 r=0", q, r); end
        run_div(4'd15, 2'd1, q, r, z, lat, bc);
        checks++; if (q !== 15 || r !== 0) begin errors++; $display("FAIL d15_1_result got q=%0d r=%0d want q=15 r=0", q, r); end
    endtask

    task automatic test_start_in_run();
        int lat;
        @(negedge clk);
        dividend = 4'd13; divisor = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int c = 0; c < TMO; c++) begin
            if (done) begin lat = c + 1; break; end
            if (c == 1) begin
                start = 1'b1; dividend = 4'd5; divisor = 2'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++; if (lat !== N + 1) begin errors++; $display("FAIL ignore_start_latency got %0d want %0d", lat, N + 1); end
        checks++; if (quotient !== 4'd4 || remainder !== 2'd1) begin errors++; $display("FAIL ignore_start_result got q=%0d r=%0d want q=4 r=1", quotient, remainder); end
        @(posedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL ignore_start_no_rerun got %b want 00", {busy, done}); end
    endtask

    task automatic test_reset_mid_run();
        int q, r, z, lat, bc;
        int seen_done;
        @(negedge clk);
        dividend = 4'd13; divisor = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            errors++; $display("FAIL midrun_reset got busy=%b done=%b dbz=%b q=%0d r=%0d want all 0", busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk); rst_n = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 2 * N + 2; c++) begin
            @(posedge clk); #1;
            seen_done += int'(done) + int'(busy);
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL midrun_no_done got %0d active cycles want 0", seen_done); end
        run_div(4'd6, 2'd2, q, r, z, lat, bc);
        checks++; if (q !== 3 || r !== 0 || lat !== N + 1) begin errors++; $display("FAIL after_reset_6_2 got q=%0d r=%0d lat=%0d want q=3 r=0 lat=%0d", q, r, lat, N + 1); end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        @(negedge clk);
        dividend = 4'd13; divisor = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        c1 = -1;
        for (int c = 0; c < TMO; c++) begin
            if (done) begin c1 = c; break; end
            @(posedge clk); #1;
        end
        checks++; if (c1 !== N || quotient !== 4'd4 || remainder !== 2'd1) begin
            errors++; $display("FAIL b2b_first got at=%0d q=%0d r=%0d want at=%0d q=4 r=1", c1, quotient, remainder, N);
        end
        dividend = 4'd9; divisor = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        c2 = -1;
        for (int c = c1 + 1; c < c1 + 1 + TMO; c++) begin
            if (done) begin c2 = c; break; end
            @(posedge clk); #1;
        end
        checks++; if (c2 - c1 !== N + 1) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", c2 - c1, N + 1); end
        checks++; if (quotient !== 4'd3 || remainder !== 2'd0) begin errors++; $display("FAIL b2b_second got q=%0d r=%0d want q=3 r=0", quotient, remainder); end
    endtask

    task automatic test_div_zero();
        int q, r, z, lat, bc;
        int eq, er, ez, elat, ebc;
        ref_div(10, 0, eq, er, ez, elat, ebc);
        run_div(4'd10, 2'd0, q, r, z, lat, bc);
        checks++; if (lat !== elat || bc !== ebc) begin errors++; $display("FAIL dbz_timing got lat=%0d busy=%0d want lat=%0d busy=%0d", lat, bc, elat, ebc); end
        checks++; if (q !== eq || r !== er || z !== ez) begin errors++; $display("FAIL dbz_result got q=%0d r=%0d z=%0d want q=%0d r=%0d z=%0d", q, r, z, eq, er, ez); end
        run_div(4'd7, 2'd2, q, r, z, lat, bc);
        checks++; if (q !== 3 || r !== 1 || z !== 0) begin errors++; $display("FAIL dbz_clear got q=%0d r=%0d z=%0d want q=3 r=1 z=0", q, r, z); end
    endtask

    task automatic test_random();
        int q, r, z, lat, bc;
        int eq, er, ez, elat, ebc;
        logic [N-1:0] dd;
        logic [M-1:0] ds;
        for (int i = 0; i < 40; i++) begin
            dd = N'($urandom_range(0, (1 << N) - 1));
            ds = M'($urandom_range(0, (1 << M) - 1));
            ref_div(int'(dd), int'(ds), eq, er, ez, elat, ebc);
            run_div(dd, ds, q, r, z, lat, bc);
            checks++;
            if (q !== eq || r !== er || z !== ez || lat !== elat || bc !== ebc) begin
                errors++;
                $display("FAIL rand_%0d_%0d got q=%0d r=%0d z=%0d lat=%0d busy=%0d want q=%0d r=%0d z=%0d lat=%0d busy=%0d",
                         dd, ds, q, r, z, lat, bc, eq, er, ez, elat, ebc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_in_run();
        test_reset_mid_run();
        test_back_to_back();
        test_div_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
